countdown_timer: RTL and testbench

//  Third display mode next to stopwatch and clock: a settable MM:SS countdown timer.
//  It consumes debounced buttons and the 1 Hz clock, and drives a 16-bit BCD word into mode_selection.

---
 rtl/timer_pkg.sv | 46 ++++
 rtl/edge_detect.sv | 21 ++
 rtl/countdown_timer.sv | 142 ++++++++++++++
 tb/tb_countdown_timer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding, display constants and BCD helper for the timer modes
// Purpose: common definitions for countdown_timer (stopwatch and clock reuse them).
// Contents: state_t, BLANK_CODE, BCD digit limits, two-digit BCD step function.
package timer_pkg;

  typedef enum logic [2:0] {
    SET_MIN = 3'd0,
    SET_SEC = 3'd1,
    RUN     = 3'd2,
    PAUSE   = 3'd3,
    EXPIRED = 3'd4
  } state_t;

  // Nibble that seven_segment_display renders as an unlit digit.
  localparam logic [3:0] BLANK_CODE = 4'hF;

  localparam logic [3:0] BCD_MAX9 = 4'd9;
  localparam logic [3:0] BCD_MAX5 = 4'd5;

  // Step a two-digit BCD value {tens, ones} by +1 (inc=1) or -1 (inc=0),
  // wrapping between 00 and {tens_max, 9}.
  function automatic logic [7:0] bcd2_step(input logic [7:0] v, input logic inc,
                                           input logic [3:0] tens_max);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = v[7:4];
    ones = v[3:0];
    if (inc) begin
      if (ones == BCD_MAX9) begin
        ones = 4'd0;
        tens = (tens == tens_max) ? 4'd0 : tens + 4'd1;
      end else begin
        ones = ones + 4'd1;
      end
    end else begin
      if (ones == 4'd0) begin
        ones = BCD_MAX9;
        tens = (tens == 4'd0) ? tens_max : tens - 4'd1;
      end else begin
        ones = ones - 4'd1;
      end
    end
    return {tens, ones};
  endfunction

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - rising-edge detector with a reset-high history register
// Purpose: turn a debounced level into a one-cycle event.
// Ports: clk, rst_n (async active-low), level (input level), pulse (level & ~prev).
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  logic prev;

  // History resets high so a level held through reset never looks like a new press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b1;
    else        prev <= level;
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - settable MM:SS countdown timer with blinking edit digits
// Purpose: FSM, BCD time register and blink/blank mux for the countdown display mode.
// Ports: CLK, RST_N (async active-low), CLK_1Hz (tick on rising edge),
//        start/sel/up_btn/dwn_btn (debounced levels),
//        numbers (BCD {m_tens,m_ones,s_tens,s_ones}, blanked nibbles = BLANK_CODE),
//        done (EXPIRED), running (RUN).
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned BLINK_DIV   = 50_000_000,
  parameter logic [7:0]  DEFAULT_MIN = 8'h05
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CLK_1Hz,
  input  logic        start,
  input  logic        sel,
  input  logic        up_btn,
  input  logic        dwn_btn,
  output logic [15:0] numbers,
  output logic        done,
  output logic        running
);

  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

  logic tick_ev, start_ev, sel_ev, up_ev, dwn_ev;

  edge_detect u_tick  (.clk(CLK), .rst_n(RST_N), .level(CLK_1Hz), .pulse(tick_ev));
  edge_detect u_start (.clk(CLK), .rst_n(RST_N), .level(start),   .pulse(start_ev));
  edge_detect u_sel   (.clk(CLK), .rst_n(RST_N), .level(sel),     .pulse(sel_ev));
  edge_detect u_up    (.clk(CLK), .rst_n(RST_N), .level(up_btn),  .pulse(up_ev));
  edge_detect u_dwn   (.clk(CLK), .rst_n(RST_N), .level(dwn_btn), .pulse(dwn_ev));

  state_t        state, state_n;
  logic [15:0]   tm, tm_n;          // {m_tens, m_ones, s_tens, s_ones}
  logic [15:0]   preset, preset_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          phase, phase_n;
  logic [15:0]   numbers_n;
  logic          done_n, running_n;

  // One-second decrement with BCD borrow; minutes only borrow from at :00,
  // which never wraps because RUN is left as soon as 00:00 is reached.
  logic [7:0]  sec_dec, min_dec;
  logic [15:0] tm_dec;
  assign sec_dec = bcd2_step(tm[7:0], 1'b0, BCD_MAX5);
  assign min_dec = (tm[7:0] == 8'h00) ? bcd2_step(tm[15:8], 1'b0, BCD_MAX9) : tm[15:8];
  assign tm_dec  = {min_dec, sec_dec};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= SET_MIN;
      tm      <= {DEFAULT_MIN, 8'h00};
      preset  <= {DEFAULT_MIN, 8'h00};
      cnt     <= '0;
      phase   <= 1'b0;
      numbers <= {DEFAULT_MIN, 8'h00};
      done    <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_n;
      tm      <= tm_n;
      preset  <= preset_n;
      cnt     <= cnt_n;
      phase   <= phase_n;
      numbers <= numbers_n;
      done    <= done_n;
      running <= running_n;
    end
  end

  always_comb begin
    state_n  = state;
    tm_n     = tm;
    preset_n = preset;
    case (state)
      SET_MIN, SET_SEC: begin
        if (start_ev) begin
          if (tm != 16'h0000) begin
            preset_n = tm;
            state_n  = RUN;
          end
        end else if (sel_ev) begin
          state_n = (state == SET_MIN) ? SET_SEC : SET_MIN;
        end else if (up_ev && dwn_ev) begin
          tm_n = tm;
        end else if (up_ev || dwn_ev) begin
          if (state == SET_MIN) tm_n[15:8] = bcd2_step(tm[15:8], up_ev, BCD_MAX9);
          else                  tm_n[7:0]  = bcd2_step(tm[7:0],  up_ev, BCD_MAX5);
        end
      end
      RUN: begin
        // The tick is applied first so a same-cycle start pauses on the new value.
        if (tick_ev) tm_n = tm_dec;
        if (tick_ev && tm_dec == 16'h0000) state_n = EXPIRED;
        else if (start_ev)                 state_n = PAUSE;
      end
      PAUSE: begin
        if (start_ev)    state_n = RUN;
        else if (sel_ev) state_n = SET_MIN;
      end
      EXPIRED: begin
        if (start_ev || sel_ev) begin
          state_n = SET_MIN;
          tm_n    = preset;
        end
      end
      default: state_n = SET_MIN;
    endcase
  end

  // Blink phase; an edit press restarts it so the edited digit shows at once.
  always_comb begin
    cnt_n   = cnt + 1'b1;
    phase_n = phase;
    if (up_ev || dwn_ev) begin
      cnt_n   = '0;
      phase_n = 1'b0;
    end else if (cnt == CNT_MAX) begin
      cnt_n   = '0;
      phase_n = ~phase;
    end
  end

  // Outputs are registered from next-state values so they line up with the state.
  always_comb begin
    numbers_n = tm_n;
    if (phase_n) begin
      case (state_n)
        SET_MIN: numbers_n[15:8] = {BLANK_CODE, BLANK_CODE};
        SET_SEC: numbers_n[7:0]  = {BLANK_CODE, BLANK_CODE};
        EXPIRED: numbers_n       = {4{BLANK_CODE}};
        default: numbers_n       = tm_n;
      endcase
    end
    done_n    = (state_n == EXPIRED);
    running_n = (state_n == RUN);
  end

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - self-checking bench for countdown_timer with a behavioural model
module tb_countdown_timer;

  localparam int BLINK = 8;
  localparam logic [4:0] TK = 5'b10000;
  localparam logic [4:0] ST = 5'b01000;
  localparam logic [4:0] SL = 5'b00100;
  localparam logic [4:0] UP = 5'b00010;
  localparam logic [4:0] DN = 5'b00001;

  localparam int M_MIN = 0, M_SEC = 1, M_RUN = 2, M_PAU = 3, M_EXP = 4;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        CLK_1Hz = 1'b0;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic        up_btn = 1'b0;
  logic        dwn_btn = 1'b0;
  logic [15:0] numbers;
  logic        done;
  logic        running;

  int checks = 0;
  int failures = 0;

  countdown_timer #(.BLINK_DIV(BLINK), .DEFAULT_MIN(8'h05)) dut (
    .CLK(CLK), .RST_N(RST_N), .CLK_1Hz(CLK_1Hz), .start(start), .sel(sel),
    .up_btn(up_btn), .dwn_btn(dwn_btn), .numbers(numbers), .done(done), .running(running)
  );

  initial forever #5 CLK = ~CLK;

  // Behavioural model: minutes/seconds as integers, blink phase from cycles since last edit.
  int   m_mode = M_MIN;
  int   mm = 5, ss = 0, pm = 5, ps = 0;
  int   bcnt = 0;
  logic p_tk = 1, p_st = 1, p_sl = 1, p_up = 1, p_dn = 1;

  task automatic model_reset();
    m_mode = M_MIN; mm = 5; ss = 0; pm = 5; ps = 0; bcnt = 0;
    p_tk = 1; p_st = 1; p_sl = 1; p_up = 1; p_dn = 1;
  endtask

  task automatic model_step();
    logic t_e, s_e, l_e, u_e, d_e;
    int tot;
    t_e = CLK_1Hz & ~p_tk; s_e = start & ~p_st; l_e = sel & ~p_sl;
    u_e = up_btn & ~p_up;  d_e = dwn_btn & ~p_dn;
    p_tk = CLK_1Hz; p_st = start; p_sl = sel; p_up = up_btn; p_dn = dwn_btn;
    if (u_e || d_e) bcnt = 0; else bcnt++;
    case (m_mode)
      M_MIN, M_SEC: begin
        if (s_e) begin
          if (mm != 0 || ss != 0) begin pm = mm; ps = ss; m_mode = M_RUN; end
        end else if (l_e) m_mode = (m_mode == M_MIN) ? M_SEC : M_MIN;
        else if (u_e && d_e) ;
        else if (u_e) begin
          if (m_mode == M_MIN) mm = (mm + 1) % 100; else ss = (ss + 1) % 60;
        end else if (d_e) begin
          if (m_mode == M_MIN) mm = (mm + 99) % 100; else ss = (ss + 59) % 60;
        end
      end
      M_RUN: begin
        if (t_e) begin
          tot = mm * 60 + ss - 1;
          mm = tot / 60; ss = tot % 60;
        end
        if (t_e && mm == 0 && ss == 0) m_mode = M_EXP;
        else if (s_e) m_mode = M_PAU;
      end
      M_PAU: begin
        if (s_e) m_mode = M_RUN;
        else if (l_e) m_mode = M_MIN;
      end
      default: begin
        if (s_e || l_e) begin mm = pm; ss = ps; m_mode = M_MIN; end
      end
    endcase
  endtask

  function automatic logic [15:0] model_numbers();
    logic [15:0] w;
    w = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    if (((bcnt / BLINK) % 2) == 1) begin
      if (m_mode == M_MIN) w[15:8] = 8'hFF;
      else if (m_mode == M_SEC) w[7:0] = 8'hFF;
      else if (m_mode == M_EXP) w = 16'hFFFF;
    end
    return w;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge CLK or negedge RST_N);
    if (!RST_N) model_reset();
    else        model_step();
  end

  initial forever begin
    @(negedge CLK);
    chk("model_numbers", numbers, model_numbers());
    chk("model_done",    {15'd0, done},    {15'd0, m_mode == M_EXP});
    chk("model_running", {15'd0, running}, {15'd0, m_mode == M_RUN});
  end

  task automatic press(input logic [4:0] m);
    @(negedge CLK);
    {CLK_1Hz, start, sel, up_btn, dwn_btn} = m;
    @(negedge CLK);
    {CLK_1Hz, start, sel, up_btn, dwn_btn} = 5'b0;
  endtask

  logic [15:0] min_tbl [6] = '{16'h0400, 16'h0300, 16'h0200, 16'h0100, 16'h0000, 16'h9900};
  int n0, nf;

  initial begin
    repeat (3) @(negedge CLK);
    chk("reset_numbers", numbers, 16'h0500);
    chk("reset_done", {15'd0, done}, 16'd0);
    chk("reset_running", {15'd0, running}, 16'd0);
    RST_N = 1'b1;

    // Reset in the middle of RUN with start held through release.
    press(ST);
    chk("t1_running", {15'd0, running}, 16'd1);
    press(TK); chk("t1_tick1", numbers, 16'h0459);
    press(TK); chk("t1_tick2", numbers, 16'h0458);
    @(negedge CLK);
    start = 1'b1;
    #2 RST_N = 1'b0;
    #1;
    chk("t1_async_numbers", numbers, 16'h0500);
    chk("t1_async_done", {15'd0, done}, 16'd0);
    chk("t1_async_running", {15'd0, running}, 16'd0);
    @(negedge CLK); @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    chk("t1_no_start_event", {15'd0, running}, 16'd0);
    start = 1'b0;

    // Minutes wrap downward, then seconds.
    for (int i = 0; i < 6; i++) begin
      press(DN);
      chk("t2_min_dwn", numbers, min_tbl[i]);
    end
    press(SL);
    press(DN); chk("t2_sec_dwn", numbers, 16'h9959);

    // Simultaneous up/dwn, then a blink phase reset by up.
    press(UP | DN); chk("t6_updn", numbers, 16'h9959);
    repeat (8) @(negedge CLK);
    chk("t6_blank_sec", numbers, 16'h99FF);
    press(UP); chk("t6_up_wrap", numbers, 16'h9900);

    // 00:03 countdown to expiry.
    press(SL);
    press(UP); chk("t3_min_wrap", numbers, 16'h0000);
    press(ST); chk("t3_start_zero_ignored", {15'd0, running}, 16'd0);
    press(SL);
    repeat (3) press(UP);
    chk("t3_set", numbers, 16'h0003);
    press(ST); chk("t3_running", {15'd0, running}, 16'd1);
    press(TK); chk("t3_tick1", numbers, 16'h0002);
    press(TK); chk("t3_tick2", numbers, 16'h0001);
    press(TK);
    chk("t3_done", {15'd0, done}, 16'd1);
    chk("t3_not_running", {15'd0, running}, 16'd0);

    // Expired blink and return to preset.
    n0 = 0; nf = 0;
    repeat (16) begin
      @(negedge CLK);
      if (numbers == 16'h0000) n0++;
      else if (numbers == 16'hFFFF) nf++;
    end
    chk("t5_visible_cycles", 16'(n0), 16'd8);
    chk("t5_blank_cycles", 16'(nf), 16'd8);
    press(SL);
    chk("t5_done_clear", {15'd0, done}, 16'd0);
    chk("t5_preset_sec", {8'h00, numbers[7:0]}, 16'h0003);
    for (int k = 0; k < 20 && numbers[15:8] == 8'hFF; k++) @(negedge CLK);
    chk("t5_preset", numbers, 16'h0003);

    // 01:00, tick, start+tick pause, paused ticks ignored, resume.
    press(UP); chk("t4_min", numbers, 16'h0103);
    press(SL);
    repeat (3) press(DN);
    chk("t4_set", numbers, 16'h0100);
    press(ST);
    press(TK); chk("t4_borrow", numbers, 16'h0059);
    press(TK | ST);
    chk("t4_pause_val", numbers, 16'h0058);
    chk("t4_paused", {15'd0, running}, 16'd0);
    for (int i = 0; i < 5; i++) begin
      press(TK); chk("t4_pause_hold", numbers, 16'h0058);
    end
    press(ST); chk("t4_resume", {15'd0, running}, 16'd1);
    press(TK); chk("t4_resume_tick", numbers, 16'h0057);

    // Randomized stimulus against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      if ($urandom_range(0, 2) == 0) CLK_1Hz = ~CLK_1Hz;
      if ($urandom_range(0, 9) == 0) start = ~start;
      if ($urandom_range(0, 9) == 0) sel = ~sel;
      if ($urandom_range(0, 3) == 0) up_btn = ~up_btn;
      if ($urandom_range(0, 3) == 0) dwn_btn = ~dwn_btn;
      if (c == 1500) begin
        #2 RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
      end
    end
    {CLK_1Hz, start, sel, up_btn, dwn_btn} = 5'b0;
    repeat (4) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
